hc245_bus_arbiter: RTL

Synchronous controller that shares one common data bus between up to `N_REQ` 74HC245-style octal transceivers. For each transceiver it drives the active-low output-enable pin (p19) and the direction pin (p1). It guarantees that at most one transceiver is enabled at any time, that direction only changes while that transceiver is disabled, and that a dead bus cycle separates consecutive owners. It sits between the bus-master logic (requesters) and the bank of transceiver models on the board-level netlist.

---
 rtl/hc245_bus_arbiter_if.sv | 15 +
 rtl/hc245_bus_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/hc245_bus_arbiter_if.sv
// Bus-side signal bundle between the requesters and the hc245 arbiter.
// master = requester/bench side, slave = arbiter side.
interface hc245_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] dir_req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] oe_n;
    logic [N_REQ-1:0] dir;
    logic             busy;

    modport master (output req, dir_req, input gnt, oe_n, dir, busy);
    modport slave  (input req, dir_req, output gnt, oe_n, dir, busy);
endinterface

// File: rtl/hc245_bus_arbiter.sv
// Round-robin owner arbitration for a bank of 74HC245 transceivers sharing one bus.
// Drives per-transceiver OE_n (p19) and DIR (p1) with a setup cycle and dead turn cycles.
//
// state  | meaning
// IDLE   | bus free, search requesters from the RR pointer
// SETUP  | dir[w] settled, oe_n[w] still high
// ACTIVE | oe_n[w] low, gnt[w] high, hold counter running
// TURN   | all enables high for TURN_CYCLES dead cycles
module hc245_bus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hc245_bus_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (MAX_HOLD > 0) ? (($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [2:0]    TURN_LOAD = 3'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, TURN} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    w_q, w_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [2:0]       turn_q, turn_d;
    logic [N_REQ-1:0] dir_q, dir_d;
    logic [N_REQ-1:0] oe_n_q, oe_n_d;
    logic             busy_q, busy_d;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    cand;
    logic             pick_vld;
    logic             others_req;

    // Walk offsets downwards so the smallest offset from the RR pointer wins.
    always_comb begin
        pick     = rr_q;
        cand     = rr_q;
        pick_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = IW'((int'(rr_q) + i) % N_REQ);
            if (bus.req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign others_req = (bus.req & ~(N_REQ'(1) << w_q)) != '0;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    w_d         = pick;
                    dir_d[pick] = bus.dir_req[pick];
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                hold_d  = '0;
                state_d = bus.req[w_q] ? ACTIVE : IDLE;
            end
            ACTIVE: begin
                // Saturate so a late-arriving waiter pre-empts a long-running owner at once.
                if (hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
                if (!bus.req[w_q] || ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && others_req)) begin
                    state_d = TURN;
                    turn_d  = TURN_LOAD;
                    rr_d    = (w_q == IW'(N_REQ - 1)) ? '0 : w_q + 1'b1;
                end
            end
            TURN: begin
                if (turn_q == 3'd0) state_d = IDLE;
                else                turn_d  = turn_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase

        oe_n_d = '1;
        if (state_d == ACTIVE) oe_n_d[w_d] = 1'b0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            rr_q    <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            dir_q   <= '0;
            oe_n_q  <= '1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            dir_q   <= dir_d;
            oe_n_q  <= oe_n_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.oe_n = oe_n_q;
    assign bus.gnt  = ~oe_n_q;
    assign bus.dir  = dir_q;
    assign bus.busy = busy_q;
endmodule
